// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and width helpers
// for the round-robin stream arbiter.
package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // clog2 that never returns less than one bit
  function automatic int unsigned clog2_min1(
    input int unsigned n
  );
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority pick of the first
// set request at or after ptr.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int NR_REQ = 4,
  parameter int ID_LEN = clog2_min1(NR_REQ)
) (
  input  logic [NR_REQ-1:0] req,
  input  logic [ID_LEN-1:0] ptr,
  output logic [ID_LEN-1:0] win,
  output logic              any
);

  logic [2*NR_REQ-1:0] dbl;
  logic [2*NR_REQ-1:0] rot;
  logic [ID_LEN:0]     off;
  logic [ID_LEN:0]     sum;

  assign dbl = {req, req};
  assign rot = dbl >> ptr;
  assign any = |req;

  // lowest set bit of the rotated window,
  // mapped back to an absolute index
  always_comb begin
    off = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (ID_LEN+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (ID_LEN+1)'(NR_REQ))
      sum = sum - (ID_LEN+1)'(NR_REQ);
    win = sum[ID_LEN-1:0];
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: packet-granular round-robin
// mux of NR_REQ valid/ready streams onto one.
module rr_stream_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NR_REQ    = 4,
  parameter int DATA_LEN  = 8,
  parameter int MAX_BEATS = 16,
  parameter int ID_LEN    = clog2_min1(NR_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NR_REQ-1:0]          req_valid,
  input  logic [NR_REQ*DATA_LEN-1:0] req_data,
  input  logic [NR_REQ-1:0]          req_last,
  output logic [NR_REQ-1:0]          req_ready,
  output logic                       out_valid,
  output logic [DATA_LEN-1:0]        out_data,
  output logic                       out_last,
  output logic [ID_LEN-1:0]          out_id,
  input  logic                       out_ready,
  output logic                       overrun
);

  localparam int CNT_LEN =
    clog2_min1(MAX_BEATS + 1);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  localparam logic [CNT_LEN-1:0] CNT_TOP =
    CNT_LEN'(MAX_BEATS - 1);
  localparam logic [ID_LEN-1:0] ID_TOP =
    ID_LEN'(NR_REQ - 1);

  logic [0:0]          state;
  logic [ID_LEN-1:0]   ptr;
  logic [ID_LEN-1:0]   gnt;
  logic [CNT_LEN-1:0]  beat_cnt;

  logic [ID_LEN-1:0]   win;
  logic                any;
  logic                busy;
  logic                cut;
  logic                xfer;
  logic [ID_LEN-1:0]   ptr_nxt;

  rr_pick #(
    .NR_REQ (NR_REQ),
    .ID_LEN (ID_LEN)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  assign busy = (state == ST_BUSY);
  assign cut  = (beat_cnt == CNT_TOP);
  assign xfer = out_valid && out_ready;

  assign ptr_nxt =
    (gnt == ID_TOP) ? '0 : gnt + 1'b1;

  // granted lane steered to the output; all
  // outputs quiet while idle
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    if (busy) begin
      out_valid      = req_valid[gnt];
      out_data       =
        req_data[gnt*DATA_LEN +: DATA_LEN];
      out_last       = req_last[gnt] || cut;
      out_id         = gnt;
      req_ready[gnt] = out_ready;
    end
  end

  // grant FSM, beat counter, rotation pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt      <= '0;
      beat_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            gnt      <= win;
            beat_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (xfer) begin
            if (out_last) begin
              state <= ST_IDLE;
              ptr   <= ptr_nxt;
              if (!req_last[gnt])
                overrun <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter sharing one output stream among NR_REQ requesters, each sending packets as valid/ready beats terminated by `last`. A grant is held for a whole packet, capped at MAX_BEATS beats, so one source cannot monopolise the bus. It sits in front of any single-consumer resource, such as a display or UART sink, that several producer blocks must share.

## Interface
- NR_REQ, 4, number of requesters (2..16)
- DATA_LEN, 8, beat width in bits
- MAX_BEATS, 16, max beats per grant before forced release (≥1)
- ID_LEN, derived clog2(NR_REQ) (min 1), grant index width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NR_REQ  per-requester beat valid
- req_data  in  NR_REQ*DATA_LEN  packed; requester n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
- req_last  in  NR_REQ  per-requester last-beat flag
- req_ready  out  NR_REQ  per-requester accept
- out_valid  out  1  output beat valid
- out_data  out  DATA_LEN  granted requester's data
- out_last  out  1  end of grant (packet end or forced cut)
- out_id  out  ID_LEN  index of granted requester
- out_ready  in  1  downstream accept
- overrun  out  1  sticky; set when a grant is force-released

## Operation
- States: IDLE, BUSY.
- Registers: state, ptr (ID_LEN), gnt (ID_LEN), beat_cnt (clog2(MAX_BEATS+1)), overrun.
- IDLE:
  - All req_ready=0, out_valid=0.
  - If any req_valid, the winner is the first set bit scanning ptr, ptr+1, … mod NR_REQ.
  - Next edge: gnt←winner, beat_cnt←0, state←BUSY.
  - No requests: stay in IDLE.
- BUSY:
  - out_valid=req_valid[gnt]; out_data=slice gnt; out_id=gnt.
  - req_ready[gnt]=out_ready; all other req_ready=0.
  - Beat transfers when out_valid && out_ready.
  - out_last = req_last[gnt] || (beat_cnt == MAX_BEATS-1).
  - On transfer with out_last:
    - state←IDLE.
    - ptr←(gnt+1) mod NR_REQ (wraps NR_REQ-1→0).
    - If req_last[gnt]=0, overrun←1.
  - On transfer without out_last: beat_cnt+1.
  - req_valid[gnt] dropping mid-packet is legal. The arbiter waits in BUSY and keeps the grant; there is no timeout.
- overrun clears only on rst.
- Requests changing while BUSY do not affect gnt.
- ptr never changes in IDLE, so a requester granted at ptr keeps priority until served.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, beat_cnt=0, overrun=0, out_valid=0, out_last=0, out_id=0, out_data=0, req_ready=0.
- Reset asserted mid-packet aborts immediately. The partial packet is dropped with no out_last.
- Arbitration latency:
  - 1 cycle from req_valid seen in IDLE to out_valid.
  - 1 idle cycle between consecutive grants, so max throughput is P/(P+1) for P-beat packets.
- Data path in BUSY is combinational from req_* to out_*. req_ready depends combinationally on out_ready; there is no path out_ready→out_valid.
- MAX_BEATS=1: every beat is a separate grant, with out_last=1 on every beat.
- Simultaneous requests: the lowest index at or after ptr wins; other requests are untouched.

## Structure
- Package `rr_arb_pkg`: state enum {IDLE, BUSY}, and a clog2-based width function for ID_LEN/beat_cnt.
- Sub-module `rr_pick`:
  - Inputs: NR_REQ-bit request vector and ptr.
  - Outputs: winner index and any.
  - Purely combinational, via double-width vector masking.
- Top holds the FSM, counters, data slice select and ready decode.

## Test plan
- Reset then single requester: req_valid=4'b0100, 3-beat packet 0x11,0x22,0x33 with last on the third beat, out_ready=1 → out_valid first seen cycle 1, out_id=2, beats in order, out_last with 0x33, ptr=3, overrun=0.
- All four requesting continuously, 1-beat packets, from ptr=0 → grants 0,1,2,3,0 each separated by one idle cycle.
- Requester 1 sends 20 beats without last, MAX_BEATS=16 → out_last on beat 16, grant released, overrun=1 and stays set; beats 17–20 arrive under a new grant.
- out_ready held 0 for 5 cycles mid-packet → out_data stable, req_ready[gnt]=0, beat_cnt unchanged; resumes on out_ready=1.
- Requester 3 granted, then req_valid[3] dropped for 3 cycles while req_valid[0]=1 → gnt stays 3, out_valid=0, req_ready[0]=0; after requester 3 finishes, ptr wraps to 0 and requester 0 is granted.
- rst pulsed asynchronously mid-packet (between edges) → all outputs 0 immediately, state IDLE, ptr=0.
